// File: rtl/lb_arb_pkg.sv
// Shared types and default sizing for the local-buffer write arbiter.
package lb_arb_pkg;

   typedef enum logic {IDLE, GNT} lb_arb_state_e;

   localparam int unsigned LB_ARB_N_REQ     = 9;
   localparam int unsigned LB_ARB_DW        = 4;
   localparam int unsigned LB_ARB_MAX_BURST = 4;

endpackage

// File: rtl/lb_rr_pick.sv
// Rotate-priority picker: first request after ptr (wrapping), ptr itself last; excl masks candidates.
// Purely combinational, no backpressure.
module lb_rr_pick #(
   parameter int unsigned N  = 9,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic [N-1:0]  excl_i,
   output logic [N-1:0]  gnt_o,
   output logic          found_o
);

   logic [N-1:0]  cand;
   logic [PW-1:0] idx;

   assign cand = req_i & ~excl_i;

   always_comb begin
      gnt_o   = '0;
      found_o = 1'b0;
      idx     = '0;
      for (int k = 1; k <= int'(N); k++) begin
         idx = PW'((int'(ptr_i) + k) % int'(N));
         if (!found_o && cand[idx]) begin
            gnt_o[idx] = 1'b1;
            found_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lb_wr_arbiter.sv
// Round-robin owner of the local-buffer write port; grant 1 cycle after request, then 1 beat/cycle.
// lb_busy freezes the current grant; LB_ARB_BURST_EN lets a holder keep the port for up to MAX_BURST beats.
module lb_wr_arbiter
   import lb_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = LB_ARB_N_REQ,
   parameter int unsigned DW        = LB_ARB_DW,
   parameter int unsigned MAX_BURST = LB_ARB_MAX_BURST
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_vld,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_rdy,
   input  logic                lb_busy,
   output logic                local_lb_we,
   output logic [DW-1:0]       local_lb_wdata,
   output logic                pre_gnt_we,
   output logic [N_REQ-1:0]    pre_gnt_nt,
   output logic [N_REQ-1:0]    gnt_r,
   output logic                arb_idle
);

   localparam int unsigned PW = $clog2(N_REQ);

   lb_arb_state_e    state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]    g_idx;
   logic [PW-1:0]    pick_ptr;
   logic [N_REQ-1:0] pick_excl;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_found;
   logic             xfer;
   logic             last_beat;

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gnt_q[i]) g_idx = PW'(i);
      end
   end

   always_comb begin
      local_lb_wdata = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (PW'(i) == g_idx) local_lb_wdata = req_data[i*DW +: DW];
      end
   end

   assign xfer = (state_q == GNT) && req_vld[g_idx] && !lb_busy;

`ifdef LB_ARB_BURST_EN
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] beat_cnt_q, beat_cnt_d;

   assign last_beat = (beat_cnt_q == BW'(MAX_BURST - 1));

   // Counter only advances on beats that keep the grant; any release or IDLE clears it.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (state_q == IDLE) begin
         beat_cnt_d = '0;
      end else if (xfer && !last_beat) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end else if (!lb_busy) begin
         beat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) beat_cnt_q <= '0;
      else     beat_cnt_q <= beat_cnt_d;
   end
`else
   assign last_beat = 1'b1;

   if (MAX_BURST < 1) begin : g_max_burst_unused
   end
`endif

   // A holder finishing its tenure must not immediately win again over its own request.
   assign pick_excl = (xfer && last_beat) ? gnt_q : '0;
   assign pick_ptr  = (state_q == GNT) ? g_idx : rr_ptr_q;

   lb_rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .req_i   (req_vld),
      .ptr_i   (pick_ptr),
      .excl_i  (pick_excl),
      .gnt_o   (pick_gnt),
      .found_o (pick_found)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      pre_gnt_we  = 1'b0;
      pre_gnt_nt  = '0;
      local_lb_we = 1'b0;
      req_rdy     = '0;

      unique case (state_q)
         IDLE: begin
            if (|req_vld && !lb_busy) begin
               gnt_d      = pick_gnt;
               pre_gnt_we = 1'b1;
               pre_gnt_nt = pick_gnt;
               state_d    = GNT;
            end
         end
         GNT: begin
            if (!lb_busy) begin
               rr_ptr_d = g_idx;
               if (xfer) begin
                  local_lb_we = 1'b1;
                  req_rdy     = gnt_q;
               end
               // Beat accepted mid-burst keeps the grant; otherwise hand over or go idle.
               if (!(xfer && !last_beat)) begin
                  gnt_d      = pick_found ? pick_gnt : '0;
                  pre_gnt_we = 1'b1;
                  pre_gnt_nt = gnt_d;
                  state_d    = pick_found ? GNT : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         local_lb_we = 1'b0;
         req_rdy     = '0;
         pre_gnt_we  = 1'b0;
         pre_gnt_nt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= PW'(N_REQ - 1);
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt_r    = gnt_q;
   assign arb_idle = (state_q == IDLE);

endmodule

// File: tb/tb_lb_wr_arbiter.sv
// Randomized and directed bench for lb_wr_arbiter against a queue-free tenure model.
module tb_lb_wr_arbiter;

   localparam int N    = 9;
   localparam int DW   = 4;
   localparam int MAXB = 4;
`ifdef LB_ARB_BURST_EN
   localparam int TENURE = MAXB;
`else
   localparam int TENURE = 1;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_vld = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_rdy;
   logic            lb_busy = 1'b0;
   logic            local_lb_we;
   logic [DW-1:0]   local_lb_wdata;
   logic            pre_gnt_we;
   logic [N-1:0]    pre_gnt_nt;
   logic [N-1:0]    gnt_r;
   logic            arb_idle;

   int n_chk  = 0;
   int n_fail = 0;

   // model: current holder (-1 = none), round-robin pointer, beats in this tenure
   int m_holder = -1;
   int m_ptr    = N - 1;
   int m_beats  = 0;

   logic         obs_we, obs_pwe;
   logic [N-1:0] obs_rdy, obs_nt, obs_gnt;

   lb_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_vld        (req_vld),
      .req_data       (req_data),
      .req_rdy        (req_rdy),
      .lb_busy        (lb_busy),
      .local_lb_we    (local_lb_we),
      .local_lb_wdata (local_lb_wdata),
      .pre_gnt_we     (pre_gnt_we),
      .pre_gnt_nt     (pre_gnt_nt),
      .gnt_r          (gnt_r),
      .arb_idle       (arb_idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rr_win(input logic [N-1:0] v, input int from, input int excl);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (from + k) % N;
         if (v[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] r;
      r = '0;
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   task automatic step(input logic r, input logic [N-1:0] v, input logic b);
      int g, w, n_holder, n_ptr, n_beats;
      logic e_we, e_pwe, chk_wd;
      logic [N-1:0] e_rdy, e_nt;
      logic [DW-1:0] e_wd;
      logic [63:0] rnd;
      @(negedge clk);
      rst      = r;
      req_vld  = v;
      lb_busy  = b;
      rnd      = {$urandom, $urandom};
      req_data = rnd[N*DW-1:0];
      #1;
      e_we = 1'b0; e_pwe = 1'b0; chk_wd = 1'b0;
      e_rdy = '0; e_nt = '0; e_wd = '0;
      n_holder = m_holder; n_ptr = m_ptr; n_beats = m_beats;
      if (r) begin
         n_holder = -1; n_ptr = N - 1; n_beats = 0;
      end else if (m_holder < 0) begin
         if (v != 0 && !b) begin
            w = rr_win(v, m_ptr, -1);
            e_pwe = 1'b1; e_nt = onehot(w);
            n_holder = w; n_beats = 0;
         end
      end else begin
         g = m_holder;
         chk_wd = 1'b1;
         e_wd = req_data[g*DW +: DW];
         if (!b) begin
            n_ptr = g;
            if (v[g]) begin
               e_we = 1'b1; e_rdy = onehot(g);
               n_beats = m_beats + 1;
               if (n_beats >= TENURE) begin
                  w = rr_win(v, g, g);
                  e_pwe = 1'b1; e_nt = onehot(w);
                  n_holder = w; n_beats = 0;
               end
            end else begin
               w = rr_win(v, g, -1);
               e_pwe = 1'b1; e_nt = onehot(w);
               n_holder = w; n_beats = 0;
            end
         end
      end
      obs_we = local_lb_we; obs_rdy = req_rdy; obs_pwe = pre_gnt_we; obs_nt = pre_gnt_nt;
      chk("we", local_lb_we, e_we);
      chk("rdy", req_rdy, e_rdy);
      chk("pre_we", pre_gnt_we, e_pwe);
      if (e_pwe) chk("pre_nt", pre_gnt_nt, e_nt);
      if (chk_wd) chk("wdata", local_lb_wdata, e_wd);
      @(posedge clk);
      m_holder = n_holder; m_ptr = n_ptr; m_beats = n_beats;
      #1;
      obs_gnt = gnt_r;
      chk("gnt_r", gnt_r, onehot(m_holder));
      chk("idle", arb_idle, (m_holder < 0));
   endtask

   task automatic do_reset();
      step(1'b1, '0, 1'b0);
      step(1'b1, '0, 1'b0);
   endtask

   initial begin
      int c_pwe, c_b0, c_b1;
      logic [N-1:0] v;

      // reset state and first grant latency
      do_reset();
      chk("rst_gnt", obs_gnt, 9'h000);
      chk("rst_idle", arb_idle, 1'b1);
      step(1'b0, 9'h001, 1'b0);
      chk("t1_gnt", obs_gnt, 9'h001);
      chk("t1_pwe", obs_pwe, 1'b1);
      step(1'b0, 9'h001, 1'b0);
      chk("t1_we", obs_we, 1'b1);
      chk("t1_rdy", obs_rdy, 9'h001);

      // all requesting: grant walks 0..8,0
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 9'h1FF, 1'b0);
`ifndef LB_ARB_BURST_EN
         chk("t2_walk", obs_gnt, onehot(k % N));
`endif
      end

      // backpressure holds grant 3
      do_reset();
      step(1'b0, 9'h008, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 9'h008, 1'b1);
         chk("t3_hold", obs_gnt, 9'h008);
         chk("t3_nowe", obs_we, 1'b0);
      end
      step(1'b0, 9'h008, 1'b0);
      chk("t3_rel", obs_rdy, 9'h008);

      // holder 5 withdraws, 2 pending
      do_reset();
      step(1'b0, 9'h020, 1'b0);
      step(1'b0, 9'h004, 1'b0);
      chk("t4_nowe", obs_we, 1'b0);
      chk("t4_gnt", obs_gnt, 9'h004);

      // reset during a pending transfer
      do_reset();
      step(1'b0, 9'h001, 1'b0);
      step(1'b1, 9'h001, 1'b0);
      chk("t5_we", obs_we, 1'b0);
      chk("t5_gnt", obs_gnt, 9'h000);
      step(1'b0, 9'h1FF, 1'b0);
      chk("t5_ptr", obs_nt, 9'h001);

`ifdef LB_ARB_BURST_EN
      do_reset();
      step(1'b0, 9'h003, 1'b0);
      c_pwe = 0; c_b0 = 0; c_b1 = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 9'h003, 1'b0);
         if (obs_pwe) c_pwe++;
         if (k < 4 && obs_rdy == 9'h001) c_b0++;
         if (k >= 4 && obs_rdy == 9'h002) c_b1++;
      end
      chk("t6_b0", c_b0, 4);
      chk("t6_b1", c_b1, 4);
      chk("t6_pwe", c_pwe, 2);
`endif

      // randomized traffic with sticky requests, busy and rare reset
      do_reset();
      v = '0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) < 3) begin
            v = N'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & N'($urandom);
         end
         step(($urandom_range(0, 99) == 0), v, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
